// File: rtl/dffram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dffram_pkg
// Description : Shared types and helpers for the streaming flip-flop RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package dffram_pkg;

  // Controller states: normal access or initialisation sweep
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Pointer increment that wraps at DEPTH-1 rather than at 2^ADDR_W-1
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dffram_array.sv
`default_nettype none
// ============================================================================
// Module      : dffram_array
// Description : Flip-flop storage array with one synchronous write port and
//               a combinational read mux. Addresses at or beyond DEPTH drop
//               writes and read back as zero. Storage is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dffram_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              in_range;

  assign in_range = ({1'b0, addr_i} < c_depth_ext);

  // Storage write; out-of-range addresses never touch the array
  always_ff @(posedge clk_i) begin
    if (we_i && in_range) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = in_range ? mem_q[addr_i] : '0;

endmodule
`default_nettype wire

// File: rtl/dffram_stream.sv
`default_nettype none
// ============================================================================
// Module      : dffram_stream
// Description : Parametrised single-port flip-flop RAM with registered read,
//               valid strobe, direct/streaming addressing with a wrapping
//               auto-increment pointer, and a clear-sweep controller.
// Revision    : 1.0 - initial release
// ============================================================================
module dffram_stream
  import dffram_pkg::*;
#(
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       DEPTH          = 128,
  parameter int unsigned       ADDR_W         = $clog2(DEPTH),
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              mode_i,
  input  logic              load_ptr_i,
  input  logic              clear_req_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] data_oe_o,
  output logic              busy_o
);

  localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last      = ADDR_W'(DEPTH - 1);
  localparam state_e            c_rst_state = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic              w_busy;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_eff;
  logic              w_op;
  logic              w_wr;
  logic              w_rd;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign w_busy    = (state_q == ST_CLEAR);
  assign w_addr_ok = ({1'b0, addr_i} < c_depth_ext);
  // A pointer load redirects the access to addr even in stream mode
  assign w_eff     = (load_ptr_i || !mode_i) ? addr_i : ptr_q;
  assign w_op      = ena_i & ~w_busy & (we_i | re_i);
  assign w_wr      = w_op & we_i;
  assign w_rd      = w_op & ~we_i;

  dffram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // Next-state logic: sweep sequencing, access decode and pointer update
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = w_eff;
    arr_wdata = wdata_i;

    case (state_q)
      ST_CLEAR: begin
        // Sweep owns the array port; user ops are ignored entirely
        arr_addr  = sweep_q;
        arr_wdata = CLEAR_VAL;
        if (ena_i) begin
          arr_we = 1'b1;
          if (sweep_q == c_last) begin
            state_d = ST_IDLE;
            sweep_d = '0;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
      end

      ST_IDLE: begin
        if (ena_i && clear_req_i) begin
          state_d = ST_CLEAR;
        end
        arr_we = w_wr;
        if (w_rd) begin
          rdata_d  = arr_rdata;
          rvalid_d = 1'b1;
        end
        if (ena_i) begin
          if (load_ptr_i) begin
            if (!w_addr_ok) begin
              ptr_d = '0;
            end else if (w_op) begin
              ptr_d = ADDR_W'(next_ptr(32'(addr_i), DEPTH));
            end else begin
              ptr_d = addr_i;
            end
          end else if (mode_i && w_op) begin
            ptr_d = ADDR_W'(next_ptr(32'(ptr_q), DEPTH));
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset restarts any sweep from word 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= c_rst_state;
      sweep_q  <= '0;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign data_oe_o = {DATA_W{rvalid_q}};
  assign busy_o    = w_busy;

endmodule
`default_nettype wire
